// File: rtl/dual_issue_tx.sv
// Two-entry transmit staging buffer driving the producer side of the dual-issue
// valid/rdy protocol; accepts 0/1/2 in-order items per cycle, emits them in order.
module dual_issue_tx #(
  parameter int unsigned Width    = 32,
  parameter bit          PassThru = 1'b0,
  parameter int unsigned CntW     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic [1:0]       in_valid_i,
  input  logic [Width-1:0] in_data0_i,
  input  logic [Width-1:0] in_data1_i,
  output logic [1:0]       in_rdy_o,
  output logic [1:0]       tx_valid_o,
  output logic [Width-1:0] tx_data0_o,
  output logic [Width-1:0] tx_data1_o,
  input  logic [1:0]       tx_rdy_i,
  output logic [CntW-1:0]  tx_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e             occ_q, occ_d;
  logic [1:0]       occ;
  logic [Width-1:0] slot0_q, slot1_q, slot0_d, slot1_d;
  logic [1:0]       n_out, n_in, room, k;
  logic [1:0]       tx_valid_d;

  assign occ        = occ_q;
  assign tx_data0_o = slot0_q;
  assign tx_data1_o = slot1_q;

  always_comb begin
    n_out = 2'd0;
    if (tx_valid_o == 2'b11 && tx_rdy_i == 2'b11) n_out = 2'd2;
    else if (tx_valid_o[0] && tx_rdy_i[0])        n_out = 2'd1;

    // n_out never exceeds occupancy, so room stays within 0..2
    room = 2'd2 - occ;
    if (PassThru) room = room + n_out;

    in_rdy_o = 2'b00;
    if (room >= 2'd2)      in_rdy_o = 2'b11;
    else if (room == 2'd1) in_rdy_o = 2'b01;

    n_in = 2'd0;
    if (in_rdy_o == 2'b11 && in_valid_i == 2'b11) n_in = 2'd2;
    else if (in_rdy_o[0] && in_valid_i[0])        n_in = 2'd1;

    k     = occ - n_out;
    occ_d = occ_e'(k + n_in);

    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (k == 2'd1 && n_out == 2'd1) slot0_d = slot1_q;
    if (n_in != 2'd0) begin
      if (k == 2'd0)      slot0_d = in_data0_i;
      else if (k == 2'd1) slot1_d = in_data0_i;
    end
    if (n_in == 2'd2) slot1_d = in_data1_i;

    case (occ_d)
      EMPTY:   tx_valid_d = 2'b00;
      ONE:     tx_valid_d = 2'b01;
      default: tx_valid_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q      <= EMPTY;
      slot0_q    <= '0;
      slot1_q    <= '0;
      tx_cnt_o   <= '0;
      tx_valid_o <= 2'b00;
    end else if (flush_i) begin
      occ_q      <= EMPTY;
      tx_cnt_o   <= '0;
      tx_valid_o <= 2'b00;
    end else begin
      occ_q      <= occ_d;
      slot0_q    <= slot0_d;
      slot1_q    <= slot1_d;
      tx_cnt_o   <= tx_cnt_o + CntW'(n_out);
      tx_valid_o <= tx_valid_d;
    end
  end

  a_tx_valid_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    tx_valid_o[1] |-> tx_valid_o[0]);
  a_in_rdy_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_rdy_o[1] |-> in_rdy_o[0]);

endmodule

// File: tb/tb_dual_issue_tx.sv
// Randomized scoreboard bench for dual_issue_tx; two instances cover both
// PassThru settings, the PassThru=0 one with a 4-bit counter to exercise wrap.
module tb_dual_issue_tx;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [1:0]  in_valid, tx_rdy;
  logic [31:0] din0, din1;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] pick_enc();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 2)      return 2'b00;
    else if (r == 2) return 2'b10;
    else if (r < 6)  return 2'b01;
    else             return 2'b11;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit          PT = (g == 1);
    localparam int unsigned CW = (g == 0) ? 4 : 16;

    logic [1:0]    in_rdy, txv;
    logic [31:0]   d0, d1;
    logic [CW-1:0] cnt;
    logic [31:0]   q[$];
    int unsigned   mcnt = 0;
    bit            rchk = 1'b0;

    dual_issue_tx #(.Width(32), .PassThru(PT), .CntW(CW)) u_dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .flush_i    (flush),
      .in_valid_i (in_valid),
      .in_data0_i (din0),
      .in_data1_i (din1),
      .in_rdy_o   (in_rdy),
      .tx_valid_o (txv),
      .tx_data0_o (d0),
      .tx_data1_o (d1),
      .tx_rdy_i   (tx_rdy),
      .tx_cnt_o   (cnt)
    );

    // Reference model: the buffer is just a queue of items in arrival order.
    initial begin : model
      int         occ, nout, room, nin;
      logic [1:0] erdy;
      forever begin
        @(negedge clk); #1;
        if (!rst_n) begin
          q.delete();
          mcnt = 0;
          rchk = 1'b1;
        end else begin
          occ = q.size();
          check($sformatf("dut%0d tx_valid", g), txv,
                (occ >= 2) ? 2'b11 : (occ == 1) ? 2'b01 : 2'b00);
          check($sformatf("dut%0d tx_cnt", g), cnt, mcnt);
          if (rchk) begin
            check($sformatf("dut%0d reset data0", g), d0, 0);
            check($sformatf("dut%0d reset data1", g), d1, 0);
            rchk = 1'b0;
          end
          if (occ >= 2 && tx_rdy == 2'b11)      nout = 2;
          else if (occ >= 1 && tx_rdy[0])       nout = 1;
          else                                  nout = 0;
          room = 2 - occ + (PT ? nout : 0);
          erdy = (room >= 2) ? 2'b11 : (room == 1) ? 2'b01 : 2'b00;
          check($sformatf("dut%0d in_rdy", g), in_rdy, erdy);
          if (room >= 2 && in_valid == 2'b11) nin = 2;
          else if (room >= 1 && in_valid[0])  nin = 1;
          else                                nin = 0;
          if (flush) begin
            q.delete();
            mcnt = 0;
          end else begin
            if (nin >= 1) q.push_back(din0);
            if (nin == 2) q.push_back(din1);
            mcnt = (mcnt + nout) % (2 ** CW);
          end
        end
      end
    end

    // Monitor: on every downstream handshake, pop and compare the expected items.
    initial begin : monitor
      int          dn;
      logic [31:0] exp_item;
      forever begin
        @(negedge clk); #2;
        if (rst_n && !flush) begin
          if (txv == 2'b11 && tx_rdy == 2'b11) dn = 2;
          else if (txv[0] && tx_rdy[0])        dn = 1;
          else                                 dn = 0;
          for (int i = 0; i < dn; i++) begin
            if (q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL dut%0d scoreboard: item %0d sent, none expected", g, i);
            end else begin
              exp_item = q.pop_front();
              check($sformatf("dut%0d tx_data%0d", g, i), (i == 0) ? d0 : d1, exp_item);
            end
          end
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 2'b00;
    tx_rdy   = 2'b00;
    din0     = '0;
    din1     = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = !(c < 3 || (c > 60 && $urandom_range(0, 299) == 0));
      flush = (c > 60) && ($urandom_range(0, 39) == 0);
      din0  = $urandom;
      din1  = $urandom;
      if (c < 60) begin
        in_valid = 2'b11;
        tx_rdy   = 2'b11;
      end else begin
        in_valid = pick_enc();
        tx_rdy   = pick_enc();
      end
    end
    @(negedge clk); #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
